// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W  = 7;
  localparam int unsigned APB_DATA_W  = 8;
  localparam int unsigned APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // One-cycle response returned to the command side.
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
  function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
    return (timeout == 32'd0) ? 32'd1 : $clog2(timeout + 32'd1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus signals of the bridge.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // Bridge view: drives cmd_ready, responses and the APB request side.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  // Environment view: command source, response sink and APB completer.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_wdog_counter.sv
// Saturating watchdog counting consecutive wait cycles of one APB access.
module apb_wdog_counter
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned      CNT_W    = wdog_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 32'd0) ? '0 : CNT_W'(TIMEOUT - 32'd1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and hold at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted when the current wait cycle makes the count reach TIMEOUT.
  assign expired = (TIMEOUT != 32'd0) && enable && (count_q == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one command per handshake, SETUP->ACCESS transfer,
// one-cycle response, watchdog abort when PREADY never arrives.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_master_bridge_if.master bus
);

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q, rsp_d;
  logic              take_cmd_s;
  logic              cmd_ready_s;
  logic              wdog_en_s;
  logic              wdog_expired_s;

  // Only wait cycles of an access advance the watchdog.
  assign wdog_en_s = (state_q == ACCESS) && !bus.PREADY;

  apb_wdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (take_cmd_s),
    .enable  (wdog_en_s),
    .expired (wdog_expired_s)
  );

  // Next state, command capture and response generation.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_d       = '0;
    take_cmd_s  = 1'b0;
    cmd_ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid) begin
          take_cmd_s = 1'b1;
          state_d    = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so it beats a terminal watchdog count.
        if (bus.PREADY) begin
          cmd_ready_s = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_d.err   = bus.PSLVERR;
          rsp_d.rdata = pwrite_q ? '0 : bus.PRDATA;
          if (bus.cmd_valid) begin
            take_cmd_s = 1'b1;
            state_d    = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (wdog_expired_s) begin
          rsp_valid_d   = 1'b1;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take_cmd_s) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
    end else begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
    end
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State, APB request and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random
// transfers checked against a transaction-level timing/response model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command with the completer inserting 'waits' wait states.
  // Model: transfer completes after waits+1 ACCESS cycles unless waits >= TO,
  // in which case the watchdog aborts after TO wait cycles.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic slverr, input logic [DW-1:0] rd);
    logic          tmo;
    int            done_k;
    int            idx;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] exp_rd;
    tmo    = (TO != 0) && (waits >= int'(TO));
    done_k = tmo ? 2 + int'(TO) : 3 + waits;
    exp_wd = wr ? wd : 8'h00;
    exp_rd = (wr || tmo) ? 8'h00 : rd;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge PCLK);
    for (int k = 1; k <= done_k; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
      end
      idx = k - 2;
      if (k >= 2 && k < done_k) begin
        bus.PREADY  = (idx == waits);
        bus.PSLVERR = (idx == waits) ? slverr : 1'($urandom_range(0, 1));
        bus.PRDATA  = (idx == waits) ? rd : DW'($urandom);
      end else begin
        bus.PREADY  = 1'($urandom_range(0, 1));
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = DW'($urandom);
      end
      #1;
      if (k < done_k) begin
        chk("psel", {31'd0, bus.PSELx}, 32'd1);
        chk("penable", {31'd0, bus.PENABLE}, (k >= 2) ? 32'd1 : 32'd0);
        chk("paddr", {25'd0, bus.PADDR}, {25'd0, addr});
        chk("pwrite", {31'd0, bus.PWRITE}, {31'd0, wr});
        chk("pwdata", {24'd0, bus.PWDATA}, {24'd0, exp_wd});
        chk("rsp_idle", {31'd0, bus.rsp_valid}, 32'd0);
        chk("cmd_ready_busy", {31'd0, bus.cmd_ready}, (k >= 2 && idx == waits) ? 32'd1 : 32'd0);
      end else begin
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, (tmo | slverr)});
        chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, tmo});
        chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
        chk("psel_end", {31'd0, bus.PSELx}, 32'd0);
        chk("penable_end", {31'd0, bus.PENABLE}, 32'd0);
        chk("paddr_hold", {25'd0, bus.PADDR}, {25'd0, addr});
      end
    end
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    #1;
    chk("rsp_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 7'h00;
    bus.cmd_wdata = 8'h00;
    bus.PRDATA    = 8'h00;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    // Reset state
    #12;
    chk("rst_psel", {31'd0, bus.PSELx}, 32'd0);
    chk("rst_penable", {31'd0, bus.PENABLE}, 32'd0);
    chk("rst_paddr", {25'd0, bus.PADDR}, 32'd0);
    chk("rst_pwdata", {24'd0, bus.PWDATA}, 32'd0);
    chk("rst_pwrite", {31'd0, bus.PWRITE}, 32'd0);
    chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Directed scenarios
    run_xfer(1'b1, 7'h15, 8'h2A, 0, 1'b0, 8'hFF);
    run_xfer(1'b0, 7'h40, 8'h99, 3, 1'b0, 8'hC3);
    run_xfer(1'b1, 7'h33, 8'h5A, 1, 1'b1, 8'h00);
    run_xfer(1'b0, 7'h21, 8'h00, 40, 1'b0, 8'hAB);
    run_xfer(1'b0, 7'h22, 8'h00, int'(TO) - 1, 1'b0, 8'h6E);
    run_xfer(1'b1, 7'h23, 8'h11, int'(TO), 1'b0, 8'h00);

    // Back-to-back: write 0x01 then read addr 0x02 with no idle cycle
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 7'h10;
    bus.cmd_wdata = 8'h01;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 7'h02;
    bus.cmd_wdata = 8'hEE;
    #1;
    chk("b2b_setup1", {30'd0, bus.PSELx, bus.PENABLE}, 32'd2);
    chk("b2b_ready_setup", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge PCLK);
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 8'h77;
    #1;
    chk("b2b_access1", {30'd0, bus.PSELx, bus.PENABLE}, 32'd3);
    chk("b2b_ready_done", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    #1;
    chk("b2b_rsp1", {31'd0, bus.rsp_valid}, 32'd1);
    chk("b2b_rsp1_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    chk("b2b_setup2", {30'd0, bus.PSELx, bus.PENABLE}, 32'd2);
    chk("b2b_paddr2", {25'd0, bus.PADDR}, 32'h02);
    chk("b2b_pwdata2", {23'd0, bus.PWRITE, bus.PWDATA}, 32'd0);
    @(negedge PCLK);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h5C;
    #1;
    chk("b2b_gap", {31'd0, bus.rsp_valid}, 32'd0);
    chk("b2b_access2", {30'd0, bus.PSELx, bus.PENABLE}, 32'd3);
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    #1;
    chk("b2b_rsp2", {31'd0, bus.rsp_valid}, 32'd1);
    chk("b2b_rsp2_rdata", {24'd0, bus.rsp_rdata}, 32'h5C);
    chk("b2b_idle", {31'd0, bus.PSELx}, 32'd0);

    // Reset during ACCESS
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 7'h55;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_psel", {30'd0, bus.PSELx, bus.PENABLE}, 32'd0);
    chk("arst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      #1;
      chk("post_rst_quiet", {30'd0, bus.rsp_valid, bus.PSELx}, 32'd0);
    end
    run_xfer(1'b0, 7'h7F, 8'h00, 2, 1'b0, 8'h3D);

    // Random transfers against the model
    for (int n = 0; n < 16; n++) begin
      int w;
      w = (n % 4 == 3) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 5));
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
               1'($urandom_range(0, 1)), DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
